// File: rtl/enc_pkg.sv
// Shared types and helpers for the serial priority encoder.
// Build option: define ENC_MSB_FIRST_EN to pick from the highest index down.
package enc_pkg;

  // Default index width; the vector is 2**ENC_W bits wide.
  localparam int ENC_W = 3;

  // Widest vector the one-hot helper can describe (index width up to 8).
  localparam int ENC_MAX_N = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // One-hot mask with only bit idx set; callers size-cast to their own width.
  function automatic logic [ENC_MAX_N-1:0] enc_onehot(input logic [31:0] idx);
    return ENC_MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_encoder_serial_pick.sv
// Combinational find-first over 2**W bits.
// Build option: ENC_MSB_FIRST_EN selects the highest set bit, otherwise the lowest.
module priority_pick #(
  parameter int W = 3
) (
  input  logic [2**W-1:0] vec,
  output logic [W-1:0]    idx,
  output logic            nz
);

  localparam int N = 2**W;

  // Bit-reversing the scan vector lets one lowest-first search serve both orders.
  logic [N-1:0] scan;
  logic [W-1:0] found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_scan
`ifdef ENC_MSB_FIRST_EN
      assign scan[gi] = vec[N-1-gi];
`else
      assign scan[gi] = vec[gi];
`endif
    end
  endgenerate

  // Lowest set bit of the scan vector; later (lower) hits overwrite earlier ones.
  always_comb begin
    found = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (scan[i]) found = W'(i);
    end
  end

`ifdef ENC_MSB_FIRST_EN
  // Map the reversed position back to the original bit index (N-1-found).
  assign idx = ~found;
`else
  assign idx = found;
`endif

  assign nz = |vec;

endmodule

// File: rtl/priority_encoder_serial.sv
// Serial 8-to-3 encoder: accepts a code vector and emits the index of every
// set bit, one per output beat, in priority order.
// Build option: ENC_MSB_FIRST_EN emits bit N-1 first instead of bit 0.
module priority_encoder_serial
  import enc_pkg::*;
#(
  parameter int W = ENC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2**W-1:0] bcode,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            last,
  output logic            zero
);

  localparam int N = 2**W;

  state_t         state_reg, state_next;
  logic [N-1:0]   pending_reg, pending_next;
  logic [W-1:0]   a_reg, a_next;
  logic           out_valid_reg, out_valid_next;
  logic           last_reg, last_next;
  logic           zero_reg, zero_next;

  logic [N-1:0]   pick_src;
  logic [W-1:0]   pick_idx;
  logic           pick_nz;
  logic [N-1:0]   pick_rem;

  // A single picker serves both the first beat (fresh vector) and the drain.
  assign pick_src = (state_reg == IDLE) ? bcode : pending_reg;

  priority_pick #(.W(W)) u_pick (
    .vec (pick_src),
    .idx (pick_idx),
    .nz  (pick_nz)
  );

  // Vector left over once the picked bit has been emitted.
  assign pick_rem = pick_src & ~N'(enc_onehot(32'(pick_idx)));

  assign in_ready  = (state_reg == IDLE) && en;
  assign a         = a_reg;
  assign out_valid = out_valid_reg;
  assign last      = last_reg;
  assign zero      = zero_reg;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      a_reg         <= '0;
      out_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      a_reg         <= a_next;
      out_valid_reg <= out_valid_next;
      last_reg      <= last_next;
      zero_reg      <= zero_next;
    end
  end

  // Next-state logic: accept in IDLE, advance one index per handshake in EMIT.
  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    a_next         = a_reg;
    out_valid_next = out_valid_reg;
    last_next      = last_reg;
    zero_next      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (pick_nz) begin
            a_next         = pick_idx;
            pending_next   = pick_rem;
            last_next      = (pick_rem == '0);
            out_valid_next = 1'b1;
            state_next     = EMIT;
          end else begin
            zero_next = 1'b1;
          end
        end
      end
      EMIT: begin
        // Without a handshake everything holds so a stalled beat never changes.
        if (out_valid_reg && out_ready) begin
          if (pending_reg != '0) begin
            a_next       = pick_idx;
            pending_next = pick_rem;
            last_next    = (pick_rem == '0);
          end else begin
            out_valid_next = 1'b0;
            last_next      = 1'b0;
            state_next     = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_priority_encoder_serial.sv
// Self-checking bench for priority_encoder_serial with a queue-based model.
// Build option: ENC_MSB_FIRST_EN flips the expected emission order.
module tb_priority_encoder_serial;

  logic       clk = 1'b0;
  logic       rst_n, en, in_valid, out_ready;
  logic [7:0] bcode;
  logic       in_ready, out_valid, last, zero;
  logic [2:0] a;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model: queue of indices still to be emitted for the current vector.
  int   exp_q[$];
  logic m_busy = 1'b0;
  logic m_zero = 1'b0;
  int   m_a    = 0;
  int   beats  = 0;
  int   ff_first, ff_second;

  always #5 clk = ~clk;

  priority_encoder_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcode     (bcode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .zero      (zero)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Indices of all set bits, in emission order.
  task automatic build_list(input logic [7:0] v);
    exp_q.delete();
`ifdef ENC_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
`endif
  endtask

  // One clock: advance the model at the edge, then compare every output.
  task automatic tick();
    logic hs;
    hs = out_valid && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_zero = 1'b0;
      m_a    = 0;
    end else if (!m_busy) begin
      m_zero = 1'b0;
      if (in_valid && en) begin
        build_list(bcode);
        if (exp_q.size() == 0) m_zero = 1'b1;
        else begin
          m_busy = 1'b1;
          m_a    = exp_q[0];
        end
      end
    end else begin
      m_zero = 1'b0;
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_busy = 1'b0;
        else m_a = exp_q[0];
      end
    end
    if (hs) beats++;
    #1;
    chk("out_valid", int'(out_valid), int'(m_busy));
    chk("a", int'(a), m_a);
    chk("last", int'(last), int'(m_busy && exp_q.size() == 1));
    chk("zero", int'(zero), int'(m_zero));
    chk("in_ready", int'(in_ready), int'(!m_busy && en));
    $display("t=%0t rst_n=%0b en=%0b iv=%0b bcode=%02h ir=%0b ov=%0b ordy=%0b a=%0d last=%0b zero=%0b",
             $time, rst_n, en, in_valid, bcode, in_ready, out_valid, out_ready, a, last, zero);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bcode = '0;
    tick(); tick();
    chk("reset_a", int'(a), 0);
    chk("reset_ov", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();

    // Single bit vector.
    en = 1'b1; bcode = 8'b0000_0100; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_a", int'(a), 2);
    chk("single_last", int'(last), 1);
    chk("single_ir_low", int'(in_ready), 0);
    tick();
    chk("single_done_ov", int'(out_valid), 0);
    chk("single_ir_back", int'(in_ready), 1);

    // Three-bit vector, consecutive beats.
    bcode = 8'b1000_0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef ENC_MSB_FIRST_EN
    chk("b83_beat0", int'(a), 7); tick();
    chk("b83_beat1", int'(a), 1); chk("b83_nolast", int'(last), 0); tick();
    chk("b83_beat2", int'(a), 0); chk("b83_last", int'(last), 1); tick();
`else
    chk("b83_beat0", int'(a), 0); tick();
    chk("b83_beat1", int'(a), 1); chk("b83_nolast", int'(last), 0); tick();
    chk("b83_beat2", int'(a), 7); chk("b83_last", int'(last), 1); tick();
`endif
    chk("b83_idle", int'(out_valid), 0);

    // Stalled first beat.
    bcode = 8'b0001_0010; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
`ifdef ENC_MSB_FIRST_EN
      chk("stall_hold", int'(a), 4);
`else
      chk("stall_hold", int'(a), 1);
`endif
      tick();
    end
    out_ready = 1'b1;
    tick();
`ifdef ENC_MSB_FIRST_EN
    chk("stall_next", int'(a), 1);
`else
    chk("stall_next", int'(a), 4);
`endif
    chk("stall_last", int'(last), 1);
    tick();

    // All-zero vector.
    bcode = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("zero_pulse", int'(zero), 1);
    chk("zero_no_beat", int'(out_valid), 0);
    tick();
    chk("zero_drop", int'(zero), 0);

    // Enable low blocks acceptance.
    en = 1'b0; in_valid = 1'b1; bcode = 8'h81;
    for (int i = 0; i < 3; i++) tick();
    chk("en_low_no_accept", int'(out_valid), 0);

    // Enable dropped mid-drain of 0xFF.
    en = 1'b1; bcode = 8'hFF;
    tick();
    in_valid = 1'b0; en = 1'b0; beats = 0;
    for (int i = 0; i < 20 && out_valid; i++) tick();
    chk("ff_beats", beats, 8);
    chk("ff_drained", int'(out_valid), 0);

    // Reset during drain, right after the second beat.
    en = 1'b1; bcode = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ff_first = int'(a);
    tick();
    ff_second = int'(a);
    chk("ff_order", ff_second - ff_first,
`ifdef ENC_MSB_FIRST_EN
        -1
`else
        1
`endif
    );
    rst_n = 1'b0;
    tick();
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_a", int'(a), 0);
    chk("rst_last", int'(last), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_more", int'(out_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      bcode     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/priority_encoder_serial.md
# priority_encoder_serial

Sequential 8-to-3 encoder: the reverse direction of the 3-to-8 binary decoder. Accepts an 8-bit code vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per accepted output beat, in priority order. Sits between request/one-hot producers and logic that consumes binary indices, such as decoder-driven select paths.

## Interface
- W, 3: index width; vector width N = 2**W (default 8).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low; sampled on rising clk.
- en  input  1  acceptance enable; gates in_ready only.
- bcode  input  N  code vector to encode.
- in_valid  input  1  bcode valid.
- in_ready  output  1  block can accept a vector.
- a  output  W  encoded index of the current beat.
- out_valid  output  1  a is valid.
- out_ready  input  1  consumer accepts the current beat.
- last  output  1  current beat is the final index of the vector.
- zero  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- Two states: IDLE and EMIT. Internal pending register, N bits.
- in_ready = (state == IDLE) && en. This is combinational from the state register and en.
- Accept means in_valid && in_ready at a rising edge.
- Accept of a nonzero vector, p = highest-priority set bit of bcode:
  - a <= p; pending <= bcode with bit p cleared; last <= (that remainder == 0).
  - out_valid <= 1; state <= EMIT.
- Accept of an all-zero vector: state stays IDLE; zero <= 1 for one cycle; no output beat.
- EMIT, beat handshake (out_valid && out_ready):
  - If pending != 0: a <= next priority bit q; pending clears bit q; last updated.
  - If pending == 0: out_valid <= 0, last <= 0, state <= IDLE.
- EMIT without handshake: a, last and pending hold. A stalled beat never changes.
- en deassert during EMIT does not abort. The vector is drained completely.
- bcode changes during EMIT are ignored.
- Beats per vector = popcount(bcode). last is asserted on exactly one beat.

## Timing
- Reset values: a = 0, out_valid = 0, last = 0, zero = 0, pending = 0, state = IDLE. After reset, in_ready follows en.
- Latency: a vector accepted at edge k drives its first beat from edge k onward (one cycle).
- Throughput: one index per cycle while out_ready is held high.
- No bypass. in_ready stays low through the final beat cycle. The next accept is earliest one cycle after the handshake on the last beat.
- Minimum per vector: popcount + 1 cycles; an all-zero vector takes 1 cycle.
- Reset asserted mid-EMIT: all state and outputs return to reset values at that edge, and the remaining indices are discarded.
- in_valid while in_ready is low is not accepted. The producer holds it.

## Configuration
- ENC_MSB_FIRST_EN defined: priority runs from the highest index down; bit N-1 is emitted first.
- Not defined: priority runs from the lowest index up; bit 0 is emitted first.
- Affects only pick order. Handshake, timing and beat count are unchanged.

## Structure
- Package enc_pkg holds:
  - State enum {IDLE, EMIT}.
  - Default index width localparam (3).
  - Function returning the one-hot mask for an index.
- Sub-module priority_pick: combinational find-first over N bits. Outputs the index and a nonzero flag, with pick direction set by ENC_MSB_FIRST_EN. It is instantiated once, on a mux of bcode (IDLE) and pending (EMIT).

## Test plan
- Reset, then en = 1, bcode = 8'b0000_0100, out_ready = 1. Required: one beat, a = 2 with last = 1, then in_ready returns one cycle after that beat.
- bcode = 8'b1000_0011, out_ready = 1, macro undefined. Required: beats a = 0, 1, 7 on consecutive cycles; last only on 7. With the macro defined, the order is 7, 1, 0.
- bcode = 8'b0001_0010, out_ready low for 3 cycles on the first beat. Required: a = 1 held stable for 3 cycles, then a = 4 with last = 1.
- bcode = 8'h00 accepted. Required: zero pulses for 1 cycle, out_valid stays 0, state remains IDLE.
- en = 0 with in_valid = 1. Required: in_ready = 0, no accept. Separately, en dropped mid-drain of 8'hFF: all 8 beats still emitted.
- rst_n low for 1 cycle after the 2nd beat of 8'hFF. Required: out_valid = 0, a = 0, last = 0 next cycle, and no further beats.
